// File: rtl/anita_event_buffer_ring.sv
// Ring of NBUF event buffers between the event assembler and the readout.
// Tracks occupancy, overflowed events and single/double-pulse buffer release.
module anita_event_buffer_ring #(
  parameter int NBUF      = 4,
  parameter int WR_WIDTH  = 16,
  parameter int WR_DEPTH  = 128,
  parameter int DBL_CLEAR = 1,
  localparam int PW       = $clog2(NBUF),
  localparam int AW       = $clog2(WR_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [WR_WIDTH-1:0]   wr_dat_i,
  input  logic                  wr_i,
  input  logic                  event_done_i,
  input  logic [AW-2:0]         rd_addr_i,
  output logic [2*WR_WIDTH-1:0] rd_dat_o,
  input  logic                  clear_evt_i,
  output logic                  clear_evt_o,
  output logic [PW-1:0]         wr_buffer_o,
  output logic [PW-1:0]         rd_buffer_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic [31:0]           status_o
);

  localparam int BANK_DEPTH = NBUF * WR_DEPTH / 2;
  localparam int BAW        = PW + AW - 1;

  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     ovf_cnt;
  logic           pending, pending_nxt;
  logic           commit, overflow, clear_req, accept;
  logic           wr_en;
  logic [BAW-1:0] wr_idx, rd_idx;

  // Even and odd write words live in separate banks so one read fetches both halves.
  logic [WR_WIDTH-1:0] mem_even [BANK_DEPTH];
  logic [WR_WIDTH-1:0] mem_odd  [BANK_DEPTH];

  assign full_o     = (count == CW'(NBUF));
  assign rd_valid_o = (count != '0) && !pending;
  assign wr_en      = wr_i && !full_o;
  assign wr_idx     = {wr_ptr, wr_addr_i[AW-1:1]};
  assign rd_idx     = {rd_ptr, rd_addr_i};
  assign commit     = event_done_i && !full_o;
  assign overflow   = event_done_i && full_o;
  assign clear_req  = clear_evt_i && (count != '0);

  assign wr_buffer_o = wr_ptr;
  assign rd_buffer_o = rd_ptr;
  assign status_o    = {ovf_cnt, 3'b0, 5'(count), 4'b0, 4'(wr_ptr), 4'b0, 4'(rd_ptr)};

  // NOTE: the RAM arrays have no reset so they map onto block RAM; contents are undefined after reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !wr_addr_i[0]) mem_even[wr_idx] <= wr_dat_i;
    if (wr_en &&  wr_addr_i[0]) mem_odd[wr_idx]  <= wr_dat_i;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept      = 1'b0;
    pending_nxt = pending;
    if (clear_req) begin
      if (DBL_CLEAR == 0) begin
        accept = 1'b1;
      end else if (pending) begin
        accept      = 1'b1;
        pending_nxt = 1'b0;
      end else begin
        pending_nxt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf_cnt     <= '0;
      pending     <= 1'b0;
      clear_evt_o <= 1'b0;
      rd_dat_o    <= '0;
    end else begin
      // The read register samples before any same-edge write lands, giving old data.
      rd_dat_o    <= {mem_odd[rd_idx], mem_even[rd_idx]};
      pending     <= pending_nxt;
      clear_evt_o <= accept;
      if (commit) wr_ptr <= wr_ptr + PW'(1);
      if (accept) rd_ptr <= rd_ptr + PW'(1);
      case ({commit, accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (overflow && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_anita_event_buffer_ring.sv
// Self-checking bench for anita_event_buffer_ring: double-clear instance for the
// main scenarios, single-clear instance for the one-pulse release mode.
module tb_anita_event_buffer_ring;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_dat = '0;
  logic        wr = 1'b0;
  logic        event_done = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [31:0] rd_dat;
  logic        clear_in = 1'b0;
  logic        clear_out;
  logic [1:0]  wr_buffer, rd_buffer;
  logic        rd_valid, full;
  logic [31:0] status;

  logic        s_event_done = 1'b0;
  logic        s_clear_in = 1'b0;
  logic [31:0] s_rd_dat;
  logic        s_clear_out;
  logic [1:0]  s_wr_buffer, s_rd_buffer;
  logic        s_rd_valid, s_full;
  logic [31:0] s_status;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          phase;
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t     vecs[8];
  logic [31:0] sb_q[$];

  anita_event_buffer_ring #(.DBL_CLEAR(1)) u_dbl (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wr_addr_i(wr_addr), .wr_dat_i(wr_dat), .wr_i(wr),
    .event_done_i(event_done), .rd_addr_i(rd_addr), .rd_dat_o(rd_dat),
    .clear_evt_i(clear_in), .clear_evt_o(clear_out),
    .wr_buffer_o(wr_buffer), .rd_buffer_o(rd_buffer),
    .rd_valid_o(rd_valid), .full_o(full), .status_o(status)
  );

  anita_event_buffer_ring #(.DBL_CLEAR(0)) u_sgl (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wr_addr_i(7'd0), .wr_dat_i(16'd0), .wr_i(1'b0),
    .event_done_i(s_event_done), .rd_addr_i(6'd0), .rd_dat_o(s_rd_dat),
    .clear_evt_i(s_clear_in), .clear_evt_o(s_clear_out),
    .wr_buffer_o(s_wr_buffer), .rd_buffer_o(s_rd_buffer),
    .rd_valid_o(s_rd_valid), .full_o(s_full), .status_o(s_status)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_event(input logic [15:0] base, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      wr      = 1'b1;
      wr_addr = 7'(i);
      wr_dat  = base + 16'(i);
      step();
    end
    wr         = 1'b0;
    event_done = 1'b1;
    step();
    event_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
  endtask

  task automatic read_word(input logic [5:0] k, input logic [31:0] exp, input string name);
    rd_addr = k;
    sb_q.push_back(exp);
    step();
    check(name, rd_dat, sb_q.pop_front());
  endtask

  task automatic run_phase(input int phase);
    for (int i = 0; i < 8; i++)
      if (vecs[i].phase == phase)
        read_word(vecs[i].addr, vecs[i].exp, $sformatf("read_p%0d_a%0d", phase, vecs[i].addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 6'd0,  32'h1001_1000};
    vecs[1] = '{1, 6'd1,  32'h1003_1002};
    vecs[2] = '{1, 6'd63, 32'h107F_107E};
    vecs[3] = '{2, 6'd0,  32'h1001_1000};
    vecs[4] = '{2, 6'd1,  32'h1003_1002};
    vecs[5] = '{3, 6'd0,  32'h4001_4000};
    vecs[6] = '{3, 6'd5,  32'h400B_400A};
    vecs[7] = '{3, 6'd63, 32'h407F_407E};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_status", status, 32'h0);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_clear_out", clear_out, 0);
    check("rst_rd_dat", rd_dat, 32'h0);
    check("rst_sgl_status", s_status, 32'h0);
    rst_n_i = 1'b1;
    step();

    // First event into buffer 0
    write_event(16'h1000, 128);
    check("t1_wr_buffer", wr_buffer, 2'd1);
    check("t1_count", status[20:16], 5'd1);
    check("t1_rd_valid", rd_valid, 1);
    run_phase(1);

    // Fill the ring, then an overflowing event whose writes must be dropped
    write_event(16'h2000, 128);
    write_event(16'h3000, 128);
    write_event(16'h4000, 128);
    check("t2_full", full, 1);
    check("t2_wr_ptr", wr_buffer, 2'd0);
    write_event(16'hDE00, 4);
    check("t2_full_kept", full, 1);
    check("t2_ovf", status[31:24], 8'd1);
    check("t2_wr_ptr_kept", status[11:8], 4'd0);
    check("t2_count", status[20:16], 5'd4);
    run_phase(2);

    // Full ring: first clear pulse only arms, second coincides with a dropped commit
    pulse_clear();
    check("t5_pending_rd_valid", rd_valid, 0);
    check("t5_pending_no_pulse", clear_out, 0);
    check("t5_pending_count", status[20:16], 5'd4);
    clear_in   = 1'b1;
    event_done = 1'b1;
    step();
    clear_in   = 1'b0;
    event_done = 1'b0;
    check("t5_clear_pulse", clear_out, 1);
    check("t5_rd_buffer", rd_buffer, 2'd1);
    check("t5_count", status[20:16], 5'd3);
    check("t5_ovf", status[31:24], 8'd2);
    check("t5_wr_ptr", wr_buffer, 2'd0);
    check("t5_rd_valid", rd_valid, 1);
    step();
    check("t5_pulse_one_cycle", clear_out, 0);
    write_event(16'h5000, 128);
    check("t5_next_commit_count", status[20:16], 5'd4);
    check("t5_next_commit_wr", wr_buffer, 2'd1);

    // Double-pulse release from a partially filled ring
    pulse_clear();
    pulse_clear();
    check("t3_pre_count", status[20:16], 5'd3);
    check("t3_pre_rd", rd_buffer, 2'd2);
    pulse_clear();
    check("t3_first_rd_valid", rd_valid, 0);
    check("t3_first_no_pulse", clear_out, 0);
    pulse_clear();
    check("t3_second_pulse", clear_out, 1);
    check("t3_rd_buffer", rd_buffer, 2'd3);
    check("t3_count", status[20:16], 5'd2);
    check("t3_rd_valid", rd_valid, 1);
    run_phase(3);

    // Asynchronous reset mid-stream with a clear pending
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    pulse_clear();
    check("t6_pre_count", status[20:16], 5'd3);
    check("t6_pre_pending", rd_valid, 0);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_status", status, 32'h0);
    check("t6_full", full, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_wr_buffer", wr_buffer, 2'd0);
    check("t6_rd_buffer", rd_buffer, 2'd0);
    check("t6_rd_dat", rd_dat, 32'h0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    step();

    // Clears while empty are ignored and must not arm the pending flag
    pulse_clear();
    check("t4_dbl_no_pulse_a", clear_out, 0);
    pulse_clear();
    check("t4_dbl_no_pulse_b", clear_out, 0);
    check("t4_dbl_rd_buffer", rd_buffer, 2'd0);
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    check("t4_dbl_count", status[20:16], 5'd1);
    pulse_clear();
    check("t4_dbl_arm_only", clear_out, 0);
    check("t4_dbl_armed_valid", rd_valid, 0);
    pulse_clear();
    check("t4_dbl_accept", clear_out, 1);
    check("t4_dbl_rd_after", rd_buffer, 2'd1);
    check("t4_dbl_count_after", status[20:16], 5'd0);

    // Single-pulse mode
    s_clear_in = 1'b1;
    step();
    step();
    s_clear_in = 1'b0;
    check("t4_sgl_no_pulse", s_clear_out, 0);
    check("t4_sgl_rd_buffer", s_rd_buffer, 2'd0);
    s_event_done = 1'b1;
    step();
    step();
    s_event_done = 1'b0;
    check("sgl_count2", s_status[20:16], 5'd2);
    s_clear_in = 1'b1;
    step();
    s_clear_in = 1'b0;
    check("sgl_pulse", s_clear_out, 1);
    check("sgl_rd_buffer", s_rd_buffer, 2'd1);
    check("sgl_count1", s_status[20:16], 5'd1);
    check("sgl_rd_valid", s_rd_valid, 1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
